// File: rtl/ram_wr_port_arbiter.sv
// Round-robin arbiter for the single write port of a 4R1W RAM.
// Also walks every RAM entry writing zero after reset or on clear_i.
module ram_wr_port_arbiter #(
    parameter int DEPTH = 16,
    parameter int INDEX = 4,
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*INDEX-1:0] req_addr_i,
    input  logic [NREQ*WIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic                  clear_i,
    output logic [INDEX-1:0]      addr0wr_o,
    output logic                  we0_o,
    output logic [WIDTH-1:0]      data0wr_o,
    output logic                  init_done_o,
    output logic [2:0]            grant_id_o
);

    localparam logic [0:0]       S_INIT = 1'b0;
    localparam logic [0:0]       S_RUN  = 1'b1;
    localparam logic [3:0]       NREQ_W = 4'(NREQ);
    localparam logic [INDEX-1:0] LAST   = INDEX'(DEPTH - 1);

    logic [0:0]       r_state;
    logic [INDEX-1:0] r_clr_cnt;
    logic [2:0]       r_rr_ptr;
    logic             r_we;
    logic [INDEX-1:0] r_addr;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_gid;

    logic [NREQ-1:0]  w_rot;
    logic             w_any;
    logic [2:0]       w_off;
    logic [3:0]       w_sum;
    logic [2:0]       w_k;
    logic [3:0]       w_inc;
    logic [2:0]       w_nxt_ptr;
    logic             w_arb_en;
    logic [NREQ-1:0]  w_ready;
    logic             w_accept;
    logic [INDEX-1:0] w_addr;
    logic [WIDTH-1:0] w_data;

    assign w_arb_en = (r_state == S_RUN) && !clear_i;

    // Rotate valids so bit 0 is the requester at rr_ptr.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            for (int p = 0; p < NREQ; p++) begin
                if (r_rr_ptr == 3'(p)) begin
                    w_rot[i] = req_valid_i[(p + i) % NREQ];
                end
            end
        end
    end

    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = 3'(i);
            end
        end
    end

    assign w_any     = |w_rot;
    assign w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_k       = (w_sum >= NREQ_W) ? 3'(w_sum - NREQ_W) : w_sum[2:0];
    assign w_inc     = {1'b0, w_k} + 4'd1;
    assign w_nxt_ptr = (w_inc == NREQ_W) ? 3'd0 : w_inc[2:0];

    always_comb begin
        w_ready = '0;
        w_addr  = '0;
        w_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_ready[i] = w_arb_en && w_any && (w_k == 3'(i));
            if (w_ready[i]) begin
                w_addr = req_addr_i[i*INDEX +: INDEX];
                w_data = req_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_accept    = |w_ready;
    assign req_ready_o = w_ready;

    // clear_i outranks both the clear walk and arbitration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_INIT;
            r_clr_cnt <= '0;
            r_rr_ptr  <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_gid     <= '0;
        end else if (clear_i) begin
            r_state   <= S_INIT;
            r_clr_cnt <= '0;
            r_we      <= 1'b0;
        end else if (r_state == S_INIT) begin
            r_we      <= 1'b1;
            r_addr    <= r_clr_cnt;
            r_data    <= '0;
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (r_clr_cnt == LAST) begin
                r_state <= S_RUN;
            end
        end else if (w_accept) begin
            r_we     <= 1'b1;
            r_addr   <= w_addr;
            r_data   <= w_data;
            r_gid    <= w_k;
            r_rr_ptr <= w_nxt_ptr;
        end else begin
            r_we <= 1'b0;
        end
    end

    assign we0_o       = r_we;
    assign addr0wr_o   = r_addr;
    assign data0wr_o   = r_data;
    assign grant_id_o  = r_gid;
    assign init_done_o = (r_state == S_RUN);

endmodule

// File: tb/tb_ram_wr_port_arbiter.sv
// Bench for ram_wr_port_arbiter: directed table, corner sequences and
// random traffic against a cycle-level model with RAM shadow images.
module tb_ram_wr_port_arbiter;

    localparam int DEPTH = 16;
    localparam int INDEX = 4;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       valid;
    logic [NREQ*INDEX-1:0] addr;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       ready;
    logic                  clear;
    logic [INDEX-1:0]      addr0wr_o;
    logic                  we0_o;
    logic [WIDTH-1:0]      data0wr_o;
    logic                  init_done_o;
    logic [2:0]            grant_id_o;

    ram_wr_port_arbiter #(
        .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .NREQ(NREQ)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid_i(valid),
        .req_addr_i(addr),
        .req_data_i(data),
        .req_ready_o(ready),
        .clear_i(clear),
        .addr0wr_o(addr0wr_o),
        .we0_o(we0_o),
        .data0wr_o(data0wr_o),
        .init_done_o(init_done_o),
        .grant_id_o(grant_id_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit       m_run;
    int       m_cnt;
    int       m_ptr;
    bit       m_we;
    int       m_addr;
    int       m_data;
    int       m_gid;
    int       mram [DEPTH];
    int       dram [DEPTH];
    logic [NREQ-1:0] obs_ready;

    typedef struct {
        logic [3:0] valid;
        logic       clr;
        logic [3:0] rdy;
        logic       we;
        logic [3:0] a;
        logic [7:0] d;
        logic [2:0] gid;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int pick(logic [NREQ-1:0] v, int ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_run = 0; m_cnt = 0; m_ptr = 0;
        m_we = 0; m_addr = 0; m_data = 0; m_gid = 0;
    endtask

    // One cycle: check ready before the edge, outputs 1 unit after it.
    task automatic tick();
        int k;
        logic [NREQ-1:0] er;
        #1;
        k = (m_run && !clear) ? pick(valid, m_ptr) : -1;
        er = '0;
        if (k >= 0) er[k] = 1'b1;
        obs_ready = ready;
        chk("ready", ready, er);
        if (clear) begin
            m_run = 0; m_cnt = 0; m_we = 0;
        end else if (!m_run) begin
            m_we = 1; m_addr = m_cnt; m_data = 0;
            if (m_cnt == DEPTH - 1) m_run = 1;
            m_cnt = (m_cnt + 1) % DEPTH;
        end else if (k >= 0) begin
            m_we = 1;
            m_addr = int'(addr[k*INDEX +: INDEX]);
            m_data = int'(data[k*WIDTH +: WIDTH]);
            m_gid = k;
            m_ptr = (k + 1) % NREQ;
        end else begin
            m_we = 0;
        end
        if (m_we) mram[m_addr] = m_data;
        @(posedge clk);
        #1;
        chk("we", we0_o, m_we);
        if (m_we) begin
            chk("addr", addr0wr_o, m_addr);
            chk("data", data0wr_o, m_data);
        end
        chk("gid", grant_id_o, m_gid);
        chk("done", init_done_o, m_run);
        if (we0_o) dram[addr0wr_o] = int'(data0wr_o);
    endtask

    initial begin
        tbl[0] = '{4'hf, 1'b0, 4'b0001, 1'b1, 4'd0, 8'h10, 3'd0};
        tbl[1] = '{4'hf, 1'b0, 4'b0010, 1'b1, 4'd1, 8'h11, 3'd1};
        tbl[2] = '{4'hf, 1'b0, 4'b0100, 1'b1, 4'd2, 8'h12, 3'd2};
        tbl[3] = '{4'hf, 1'b0, 4'b1000, 1'b1, 4'd3, 8'h13, 3'd3};
        tbl[4] = '{4'hf, 1'b0, 4'b0001, 1'b1, 4'd0, 8'h10, 3'd0};
        tbl[5] = '{4'h4, 1'b0, 4'b0100, 1'b1, 4'd2, 8'h12, 3'd2};
        tbl[6] = '{4'h4, 1'b0, 4'b0100, 1'b1, 4'd2, 8'h12, 3'd2};
        tbl[7] = '{4'h0, 1'b0, 4'b0000, 1'b0, 4'd2, 8'h12, 3'd2};
        tbl[8] = '{4'ha, 1'b0, 4'b1000, 1'b1, 4'd3, 8'h13, 3'd3};
        tbl[9] = '{4'h0, 1'b0, 4'b0000, 1'b0, 4'd3, 8'h13, 3'd3};

        for (int i = 0; i < DEPTH; i++) begin
            mram[i] = 0;
            dram[i] = 0;
        end
        reset = 1'b1;
        clear = 1'b0;
        valid = '0;
        addr  = {4'd3, 4'd2, 4'd1, 4'd0};
        data  = {8'h13, 8'h12, 8'h11, 8'h10};
        obs_ready = '0;
        model_reset();

        #3;
        chk("rst_we", we0_o, 0);
        chk("rst_addr", addr0wr_o, 0);
        chk("rst_data", data0wr_o, 0);
        chk("rst_gid", grant_id_o, 0);
        chk("rst_done", init_done_o, 0);
        chk("rst_ready", ready, 0);
        #10;
        reset = 1'b0;

        // Power-up clear walk, with requests pending throughout
        valid = 4'hf;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk("init_ready", obs_ready, 0);
            chk("init_we", we0_o, 1);
            chk("init_addr", addr0wr_o, i);
            chk("init_data", data0wr_o, 0);
            chk("init_done", init_done_o, (i == DEPTH - 1) ? 1 : 0);
        end
        valid = '0;
        tick();
        chk("post_init_we", we0_o, 0);
        chk("post_init_done", init_done_o, 1);

        // Directed table, round-robin pointer starts at 0
        for (int r = 0; r < 10; r++) begin
            valid = tbl[r].valid;
            clear = tbl[r].clr;
            tick();
            chk("tbl_ready", obs_ready, tbl[r].rdy);
            chk("tbl_we", we0_o, tbl[r].we);
            chk("tbl_addr", addr0wr_o, tbl[r].a);
            chk("tbl_data", data0wr_o, tbl[r].d);
            chk("tbl_gid", grant_id_o, tbl[r].gid);
        end

        // Clear while 0 and 1 are requesting; the prior write completes
        valid = 4'b0011;
        tick();
        chk("clr_pre_ready", obs_ready, 4'b0001);
        chk("clr_pre_we", we0_o, 1);
        clear = 1'b1;
        tick();
        chk("clr_ready", obs_ready, 0);
        chk("clr_we", we0_o, 0);
        chk("clr_done", init_done_o, 0);
        clear = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk("clr_walk_ready", obs_ready, 0);
            chk("clr_walk_addr", addr0wr_o, i);
            chk("clr_walk_we", we0_o, 1);
        end
        tick();
        chk("clr_resume_ready", obs_ready, 4'b0010);
        chk("clr_resume_addr", addr0wr_o, 1);
        valid = '0;
        tick();

        // Reset asserted mid clear, at address 7
        clear = 1'b1;
        tick();
        clear = 1'b0;
        begin
            int guard;
            guard = 0;
            while (!(m_we && m_addr == 7) && guard < 20) begin
                tick();
                guard++;
            end
            if (guard >= 20) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rst_mid_wait: got timeout want addr 7");
            end
        end
        chk("rst_mid_pre_addr", addr0wr_o, 7);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_we", we0_o, 0);
        chk("rst_mid_addr", addr0wr_o, 0);
        chk("rst_mid_done", init_done_o, 0);
        model_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk("rst_walk_addr", addr0wr_o, i);
            chk("rst_walk_we", we0_o, 1);
        end

        // Random traffic with withdrawals and occasional clears
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (obs_ready[r] || !valid[r]) begin
                    valid[r] = ($urandom_range(0, 2) != 0);
                    addr[r*INDEX +: INDEX] = INDEX'($urandom_range(0, DEPTH - 1));
                    data[r*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
                end else if ($urandom_range(0, 15) == 0) begin
                    valid[r] = 1'b0;
                end
            end
            clear = ($urandom_range(0, 59) == 0);
            tick();
        end
        clear = 1'b0;
        valid = '0;
        for (int c = 0; c < DEPTH + 2; c++) tick();

        for (int i = 0; i < DEPTH; i++) begin
            chk("ram_image", dram[i], mram[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_wr_port_arbiter.md
Name: ram_wr_port_arbiter

Overview:
- Shares the single write port of a 4R1W RAM (DEPTH x WIDTH) among NREQ requesters using round-robin arbitration.
- Also sequences a hardware clear: after reset and on request, it walks every RAM entry writing zero.
- Sits between writeback/producer logic and the RAM's addr0wr_i/we0_i/data0wr_i inputs.
- The RAM's read ports are untouched.

Parameters:
DEPTH 16 number of RAM entries
INDEX 4 address width, log2(DEPTH)
WIDTH 8 data width
NREQ 4 number of write requesters (2..8)

Ports:
clk input 1 clock
reset input 1 asynchronous, active-high reset
req_valid_i input NREQ per-requester write request
req_addr_i input NREQ*INDEX packed addresses, requester k at [k*INDEX +: INDEX]
req_data_i input NREQ*WIDTH packed data, requester k at [k*WIDTH +: WIDTH]
req_ready_o output NREQ one-hot grant; a request is accepted when valid & ready
clear_i input 1 start a full RAM clear
addr0wr_o output INDEX to RAM addr0wr_i
we0_o output 1 to RAM we0_i
data0wr_o output WIDTH to RAM data0wr_i
init_done_o output 1 high when not clearing (state RUN)
grant_id_o output 3 index of last accepted requester (registered)

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - state = INIT, clr_cnt = 0, rr_ptr = 0
  - we0_o = 0, addr0wr_o = 0, data0wr_o = 0, grant_id_o = 0, init_done_o = 0, req_ready_o = 0
- States: INIT (clearing) and RUN.
- INIT:
  - Each clock, register we0_o = 1, addr0wr_o = clr_cnt, data0wr_o = 0; then clr_cnt++.
  - When clr_cnt == DEPTH-1 is issued, move to RUN.
  - we0_o is high for exactly DEPTH consecutive cycles, addresses 0..DEPTH-1 in order.
  - req_ready_o = 0 throughout INIT.
- RUN, grant selection (combinational):
  - Scan the requesters starting at rr_ptr, wrapping modulo NREQ.
  - The first requester with req_valid_i set gets req_ready_o[k] = 1; all other ready bits are 0.
  - No valid requester → req_ready_o = 0.
- RUN, on an accept by requester k (registered):
  - Next edge: we0_o = 1, addr0wr_o = req_addr_i[k], data0wr_o = req_data_i[k], grant_id_o = k.
  - rr_ptr updates to (k+1) mod NREQ.
- RUN, no accept: we0_o = 0 on the next edge; addr0wr_o, data0wr_o and rr_ptr hold.
- Latency: the write appears on the RAM port exactly 1 cycle after the accept cycle. Throughput is 1 write per cycle.
- Requesters hold valid, addr and data stable until accepted. Dropping valid before ready is legal and means the request is withdrawn (no write issued).
- clear_i:
  - Sampled each cycle; it has priority over requests.
  - In RUN, a cycle with clear_i = 1 forces req_ready_o = 0 (no accept) and moves to INIT with clr_cnt = 0.
  - In INIT, clear_i = 1 restarts clr_cnt at 0.
  - The write registered in the cycle before clear_i asserts still completes.
- init_done_o = (state == RUN), registered with the state.
- Two requesters targeting the same address on consecutive grants: both writes issue in grant order; the later one wins.
- Reset asserted mid-INIT or mid-RUN: outputs go to reset values immediately (asynchronously). The sequence restarts from INIT address 0 after release.

Test Plan:
- Reset release, no requests, DEPTH=16 → we0_o=1 for 16 cycles with addr 0..15 and data 0; then init_done_o=1, we0_o=0; req_ready_o=0 during all 16 cycles.
- After init, all 4 requesters hold valid with addr=k, data=0x10+k → grants 0,1,2,3,0 on consecutive cycles; RAM writes addr 0,1,2,3 with data 0x10..0x13, each 1 cycle after its grant.
- Only requester 2 valid, rr_ptr=3 → wrap gives ready[2]=1 same cycle; next cycle we0_o=1, grant_id_o=2, rr_ptr becomes 3.
- clear_i pulsed while requesters 0 and 1 are valid → no ready that cycle; we0_o high for 16 clear cycles; arbitration resumes after init_done_o rises. A pending write from the prior cycle appears before the clear sequence.
- Reset asserted at clear address 7 → we0_o drops to 0 without waiting for a clock. After release, the clear restarts at address 0 and runs all 16 entries.
- Requester 1 drops valid before grant while requester 3 is valid → only 3 is written; no write to requester 1's address occurs.
